pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: en  input  1  advance enable; 0 = stall, all state held.
REQ-004 SHALL have ports: npc_sel  input  3  next-PC source: 0 seq, 1 branch, 2 jump (j/jal), 3 jump-register; 4-7 reserved.
REQ-005 SHALL have ports: br_taken  input  1  branch comparison result, sampled only when npc_sel=1.
REQ-006 SHALL have ports: imm16  input  16  branch offset in words.
REQ-007 SHALL have ports: instr_index  input  26  jump target field.
REQ-008 SHALL have ports: ra  input  32  register value for jump-register.
REQ-009 SHALL have ports: PC  output  32  current fetch address, registered, fed to instruction memory.
REQ-010 SHALL have ports: PC4  output  32  PC+4, combinational, link value for jal.
REQ-011 SHALL have ports: instr_cnt  output  32  count of committed PC updates.
REQ-012 SHALL have ports: addr_err  output  1  sticky illegal-target flag.
REQ-013 SHALL have ports: halted  output  1  high while in HALT state.

Function
REQ-014 SHALL hold the legal fetch window 0x0000_3000..0x0000_6FFC inclusive (4096 words), word aligned.
REQ-015 SHALL compute candidate next PC (NPC) combinationally:
- seq: PC+4
- branch, br_taken=1: PC+4+(sign-extended imm16 << 2)
- branch, br_taken=0: PC+4
- jump: {PC[31:28], instr_index, 2'b00}
- jump-register: ra
- reserved codes 4-7: PC+4.
REQ-016 SHALL use 32-bit modulo arithmetic for all adds; overflow wraps and is then caught by the window check.
REQ-017 SHALL have two states, RUN and HALT; reset enters RUN.
REQ-018 SHALL, in RUN with en=1 and NPC legal (aligned, in window): PC<=NPC and instr_cnt<=instr_cnt+1 on the next edge.
REQ-019 SHALL, in RUN with en=1 and NPC illegal (NPC[1:0]!=0 or outside window): leave PC unchanged, leave instr_cnt unchanged, set addr_err=1 and move to HALT on the same edge.
REQ-020 SHALL, in RUN with en=0: hold PC, instr_cnt, addr_err and state; no error check is performed.
REQ-021 SHALL, in HALT: hold PC, instr_cnt and addr_err=1 regardless of en or npc_sel; HALT is left only by reset.
REQ-022 SHALL drive halted=1 exactly when state is HALT.
REQ-023 SHALL treat sequential step from PC=0x6FFC (NPC=0x7000) as illegal per REQ-019.
REQ-024 SHALL let instr_cnt wrap from 0xFFFF_FFFF to 0 without flag.
REQ-025 SHALL keep PC4 = PC+4 at all times, including in HALT.
REQ-026 SHALL use a single-cycle PC update: NPC selected in cycle n appears on PC after edge n; there is no delay slot.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, set PC=0x0000_3000, instr_cnt=0, addr_err=0, state=RUN, regardless of en, state or other inputs.
REQ-028 SHALL give reset priority over every other event in the same cycle, including an illegal NPC and en=1.
REQ-029 SHALL make outputs after reset: PC=0x3000, PC4=0x3004, instr_cnt=0, addr_err=0, halted=0.

Verification
REQ-030 SHALL be covered: reset, then 3 cycles en=1 npc_sel=0 -> PC 0x3004, 0x3008, 0x300C; instr_cnt=3.
REQ-031 SHALL be covered: PC=0x3010, npc_sel=1, br_taken=1, imm16=0xFFFC -> PC=0x3004; same with br_taken=0 -> PC=0x3014.
REQ-032 SHALL be covered: PC=0x3000, npc_sel=2, instr_index=0x0000C10 -> PC=0x3040; PC4 before edge=0x3004.
REQ-033 SHALL be covered: npc_sel=3, ra=0x3002 -> PC unchanged, addr_err=1, halted=1; then ra=0x3000 with en=1 -> still halted, PC unchanged.
REQ-034 SHALL be covered: en=0 for 4 cycles with npc_sel=2 -> PC and instr_cnt unchanged; PC=0x6FFC with npc_sel=0 -> addr_err=1, PC stays 0x6FFC.
REQ-035 SHALL be covered: reset asserted while halted with en=1 -> next cycle PC=0x3000, addr_err=0, halted=0, instr_cnt=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter unit: computes the next fetch address from the selected source,
// commits it only when it lands word-aligned inside the fetch window, and halts on the first illegal target.
module pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] ra,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic [31:0] instr_cnt,
    output logic        addr_err,
    output logic        halted
);

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] WIN_LO   = 32'h0000_3000;
    localparam logic [31:0] WIN_HI   = 32'h0000_6FFC;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_BR  = 3'd1,
        SEL_J   = 3'd2,
        SEL_JR  = 3'd3
    } npc_sel_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic        npc_legal;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_off   = {{14{imm16[15]}}, imm16, 2'b00};
        npc      = pc_plus4;
        case (npc_sel)
            SEL_SEQ: npc = pc_plus4;
            SEL_BR:  npc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            SEL_J:   npc = {pc_q[31:28], instr_index, 2'b00};
            SEL_JR:  npc = ra;
            default: npc = pc_plus4;
        endcase
        npc_legal = (npc[1:0] == 2'b00) && (npc >= WIN_LO) && (npc <= WIN_HI);
    end

    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        state_d = state_q;
        if (state_q == ST_RUN && en) begin
            if (npc_legal) begin
                pc_d  = npc;
                cnt_d = cnt_q + 32'd1;
            end else begin
                err_d   = 1'b1;
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= PC_RESET;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign PC        = pc_q;
    assign PC4       = pc_plus4;
    assign instr_cnt = cnt_q;
    assign addr_err  = err_q;
    assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, a hand-written halt sequence,
// then randomized traffic compared against an arithmetic reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, en, br_taken;
    logic [2:0]  npc_sel;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] ra;
    logic [31:0] pc_o, pc4_o, cnt_o;
    logic        err_o, halted_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .en(en), .npc_sel(npc_sel), .br_taken(br_taken),
        .imm16(imm16), .instr_index(instr_index), .ra(ra),
        .PC(pc_o), .PC4(pc4_o), .instr_cnt(cnt_o), .addr_err(err_o), .halted(halted_o)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  sel;
        logic        br;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] ra;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference state, updated from the architectural rules only.
    longint unsigned m_pc, m_cnt;
    bit              m_err, m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] s, input logic b,
                         input logic [15:0] im, input logic [25:0] ix, input logic [31:0] a);
        reset = r; en = e; npc_sel = s; br_taken = b; imm16 = im; instr_index = ix; ra = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] p, input logic [31:0] c,
                           input logic er);
        chk({tag, ".PC"}, pc_o, p);
        chk({tag, ".PC4"}, pc4_o, p + 32'd4);
        chk({tag, ".instr_cnt"}, cnt_o, c);
        chk({tag, ".addr_err"}, {31'd0, err_o}, {31'd0, er});
        chk({tag, ".halted"}, {31'd0, halted_o}, {31'd0, er});
    endtask

    function automatic void add(input logic r, input logic e, input logic [2:0] s, input logic b,
                                input logic [15:0] im, input logic [25:0] ix, input logic [31:0] a,
                                input logic [31:0] p, input logic [31:0] c, input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.sel = s; v.br = b; v.imm = im; v.idx = ix; v.ra = a;
        v.exp_pc = p; v.exp_cnt = c; v.exp_err = er;
        vecs.push_back(v);
    endfunction

    function automatic void model_step(input bit r, input bit e, input int unsigned s, input bit b,
                                       input int unsigned im, input int unsigned ix,
                                       input longint unsigned a);
        longint signed   off;
        longint unsigned npc;
        if (r) begin
            m_pc = 64'h3000; m_cnt = 0; m_err = 0; m_halt = 0;
            return;
        end
        if (m_halt || !e) return;
        off = (im >= 32768) ? longint'(im) - 65536 : longint'(im);
        case (s)
            1:       npc = b ? (m_pc + 4 + off * 4) : (m_pc + 4);
            2:       npc = (m_pc / 64'h1000_0000) * 64'h1000_0000 + longint'(ix) * 4;
            3:       npc = a;
            default: npc = m_pc + 4;
        endcase
        npc = npc % 64'h1_0000_0000;
        if (npc % 4 == 0 && npc >= 64'h3000 && npc <= 64'h6FFC) begin
            m_pc  = npc;
            m_cnt = (m_cnt + 1) % 64'h1_0000_0000;
        end else begin
            m_err  = 1;
            m_halt = 1;
        end
    endfunction

    initial begin
        reset = 1'b1; en = 1'b0; npc_sel = '0; br_taken = 1'b0;
        imm16 = '0; instr_index = '0; ra = '0;
        @(posedge clk);
        #1;

        //  rst en sel br imm       idx        ra             pc            cnt  err
        add(1, 1, 3, 0, 16'h0,    26'h0,     32'h3002,      32'h3000,     0,   0);
        add(0, 1, 0, 0, 16'h0,    26'h0,     32'h0,         32'h3004,     1,   0);
        add(0, 1, 0, 0, 16'h0,    26'h0,     32'h0,         32'h3008,     2,   0);
        add(0, 1, 0, 0, 16'h0,    26'h0,     32'h0,         32'h300C,     3,   0);
        add(0, 1, 0, 0, 16'h0,    26'h0,     32'h0,         32'h3010,     4,   0);
        add(0, 1, 1, 1, 16'hFFFC, 26'h0,     32'h0,         32'h3004,     5,   0);
        add(0, 1, 2, 0, 16'h0,    26'hC04,   32'h0,         32'h3010,     6,   0);
        add(0, 1, 1, 0, 16'hFFFC, 26'h0,     32'h0,         32'h3014,     7,   0);
        add(0, 1, 2, 0, 16'h0,    26'hC00,   32'h0,         32'h3000,     8,   0);
        add(0, 1, 2, 0, 16'h0,    26'hC10,   32'h0,         32'h3040,     9,   0);
        add(0, 1, 5, 1, 16'h8000, 26'h0,     32'h0,         32'h3044,     10,  0);
        add(0, 0, 2, 0, 16'h0,    26'h0,     32'h0,         32'h3044,     10,  0);
        add(0, 0, 2, 0, 16'h0,    26'h0,     32'h0,         32'h3044,     10,  0);
        add(0, 0, 2, 0, 16'h0,    26'h0,     32'h0,         32'h3044,     10,  0);
        add(0, 0, 2, 0, 16'h0,    26'h0,     32'h0,         32'h3044,     10,  0);
        add(0, 1, 3, 0, 16'h0,    26'h0,     32'h6FFC,      32'h6FFC,     11,  0);
        add(0, 1, 0, 0, 16'h0,    26'h0,     32'h0,         32'h6FFC,     11,  1);
        add(0, 1, 3, 0, 16'h0,    26'h0,     32'h3000,      32'h6FFC,     11,  1);
        add(1, 1, 3, 0, 16'h0,    26'h0,     32'h3002,      32'h3000,     0,   0);
        add(0, 1, 3, 0, 16'h0,    26'h0,     32'h3002,      32'h3000,     0,   1);
        add(0, 1, 3, 0, 16'h0,    26'h0,     32'h3000,      32'h3000,     0,   1);
        add(1, 1, 0, 0, 16'h0,    26'h0,     32'h0,         32'h3000,     0,   0);
        add(0, 1, 1, 1, 16'h8000, 26'h0,     32'h0,         32'h3000,     0,   1);
        add(1, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h3000,     0,   0);
        add(0, 1, 3, 0, 16'h0,    26'h0,     32'h0000_7000, 32'h3000,     0,   1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].sel, vecs[i].br, vecs[i].imm, vecs[i].idx,
                  vecs[i].ra);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt, vecs[i].exp_err);
        end

        // Halted unit must ignore every input combination until reset.
        for (int unsigned i = 0; i < 8; i++) begin
            drive(0, 1'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 26'($urandom),
                  32'h3000 + 32'(i * 4));
            chk_all("halt_hold", 32'h3000, 0, 1);
        end
        drive(1, 1, 1, 1, 16'h8000, 26'h0, 32'h0);
        chk_all("halt_reset", 32'h3000, 0, 0);

        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 3000; i++) begin
            logic        r, e, b;
            logic [2:0]  s;
            logic [15:0] im;
            logic [25:0] ix;
            logic [31:0] a;
            r  = ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 3) != 0);
            s  = 3'($urandom);
            b  = 1'($urandom);
            im = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
            ix = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(32'hB00, 32'h1D00));
            a  = ($urandom_range(0, 7) == 0) ? $urandom
                                             : 32'h3000 + 32'($urandom_range(0, 4095) * 4);
            drive(r, e, s, b, im, ix, a);
            model_step(r, e, int'(s), b, int'(im), int'(ix), longint'(a));
            chk_all("rand", 32'(m_pc), 32'(m_cnt), m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
